pes_rca_acc: RTL and testbench

PES_RCA_ACC -- requirements
Module: pes_rca_acc

---
 rtl/pes_rca_acc_if.sv | 26 ++
 rtl/pes_rca_acc.sv | 82 ++++++++
 tb/tb_pes_rca_acc.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pes_rca_acc_if.sv
// Handshake bundle between the ripple-carry adder stage, the accumulator and its consumer.
// The master modport belongs to the side that drives samples and consumes results.
interface pes_rca_acc_if #(
    parameter int ACC_W = 8
);
    logic             start;
    logic [3:0]       S;
    logic             Cout;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] acc_out;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        output start, S, Cout, in_valid, out_ready,
        input  in_ready, acc_out, ovf, out_valid, busy
    );

    modport slave (
        input  start, S, Cout, in_valid, out_ready,
        output in_ready, acc_out, ovf, out_valid, busy
    );
endinterface

// File: rtl/pes_rca_acc.sv
// Accumulates NSAMP {Cout,S} results from a 4-bit ripple-carry adder into a wrapping
// ACC_W-bit sum with a sticky carry-out flag, then holds the result until consumed.
module pes_rca_acc #(
    parameter int NSAMP = 4,
    parameter int ACC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    pes_rca_acc_if.slave       bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_nxt;
    logic [ACC_W-1:0] acc_q, acc_nxt;
    logic             ovf_q, ovf_nxt;
    logic [7:0]       cnt_q, cnt_nxt;
    logic [ACC_W:0]   sum_w;

    // The extra top bit of the result is the carry out of the accumulator.
    function automatic logic [ACC_W:0] add_operand(input logic [ACC_W-1:0] acc,
                                                   input logic [4:0]       op);
        return {1'b0, acc} + {{(ACC_W-4){1'b0}}, op};
    endfunction

    assign sum_w = add_operand(acc_q, {bus.Cout, bus.S});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            acc_q   <= acc_nxt;
            ovf_q   <= ovf_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        acc_nxt   = acc_q;
        ovf_nxt   = ovf_q;
        cnt_nxt   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.in_valid) begin
                    acc_nxt = sum_w[ACC_W-1:0];
                    ovf_nxt = ovf_q | sum_w[ACC_W];
                    cnt_nxt = cnt_q + 8'd1;
                    if (cnt_q == 8'(NSAMP - 1))
                        state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decode straight from the state so reset clears them without a clock.
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.acc_out   = acc_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pes_rca_acc.sv
// Bench for pes_rca_acc: two instances (ACC_W=8 and ACC_W=6) share one stimulus stream,
// a reference model tracks each cycle and a result queue is checked on every DONE cycle.
module tb_pes_rca_acc;
    localparam int NS = 4;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    pes_rca_acc_if #(.ACC_W(8)) ifa();
    pes_rca_acc_if #(.ACC_W(6)) ifb();

    assign ifb.start     = ifa.start;
    assign ifb.S         = ifa.S;
    assign ifb.Cout      = ifa.Cout;
    assign ifb.in_valid  = ifa.in_valid;
    assign ifb.out_ready = ifa.out_ready;

    pes_rca_acc #(.NSAMP(NS), .ACC_W(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    pes_rca_acc #(.NSAMP(NS), .ACC_W(6)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model, advanced on the same edges as the DUTs.
    typedef enum int {M_IDLE, M_ACC, M_DONE} mstate_t;
    typedef struct {
        int acc8;
        bit ovf8;
        int acc6;
        bit ovf6;
    } exp_t;

    mstate_t m_state;
    int      m_acc8, m_acc6, m_cnt;
    bit      m_ovf8, m_ovf6;
    int      na8, na6;
    exp_t    exp_q[$];
    exp_t    e;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= M_IDLE;
            m_acc8  <= 0;
            m_acc6  <= 0;
            m_ovf8  <= 1'b0;
            m_ovf6  <= 1'b0;
            m_cnt   <= 0;
            exp_q.delete();
        end else begin
            case (m_state)
                M_IDLE: if (ifa.start) begin
                    m_state <= M_ACC;
                    m_acc8  <= 0;
                    m_acc6  <= 0;
                    m_ovf8  <= 1'b0;
                    m_ovf6  <= 1'b0;
                    m_cnt   <= 0;
                end
                M_ACC: if (ifa.in_valid) begin
                    na8 = m_acc8 + int'({ifa.Cout, ifa.S});
                    na6 = m_acc6 + int'({ifa.Cout, ifa.S});
                    m_acc8 <= na8 % 256;
                    m_acc6 <= na6 % 64;
                    m_ovf8 <= m_ovf8 || (na8 >= 256);
                    m_ovf6 <= m_ovf6 || (na6 >= 64);
                    m_cnt  <= m_cnt + 1;
                    if (m_cnt + 1 == NS) begin
                        m_state <= M_DONE;
                        e.acc8 = na8 % 256;
                        e.ovf8 = m_ovf8 || (na8 >= 256);
                        e.acc6 = na6 % 64;
                        e.ovf6 = m_ovf6 || (na6 >= 64);
                        exp_q.push_back(e);
                    end
                end
                M_DONE: if (ifa.out_ready) begin
                    m_state <= M_IDLE;
                    void'(exp_q.pop_front());
                end
                default: m_state <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_a",  32'(ifa.in_ready),  32'(m_state == M_ACC));
            chk("out_valid_a", 32'(ifa.out_valid), 32'(m_state == M_DONE));
            chk("busy_a",      32'(ifa.busy),      32'(m_state != M_IDLE));
            chk("acc_a",       32'(ifa.acc_out),   32'(m_acc8));
            chk("ovf_a",       32'(ifa.ovf),       32'(m_ovf8));
            chk("out_valid_b", 32'(ifb.out_valid), 32'(m_state == M_DONE));
            chk("acc_b",       32'(ifb.acc_out),   32'(m_acc6));
            chk("ovf_b",       32'(ifb.ovf),       32'(m_ovf6));
            if (m_state == M_DONE) begin
                if (exp_q.size() == 0) begin
                    chk("sb_empty", 32'(exp_q.size()), 32'd1);
                end else begin
                    chk("sb_acc_a", 32'(ifa.acc_out), 32'(exp_q[0].acc8));
                    chk("sb_ovf_a", 32'(ifa.ovf),     32'(exp_q[0].ovf8));
                    chk("sb_acc_b", 32'(ifb.acc_out), 32'(exp_q[0].acc6));
                    chk("sb_ovf_b", 32'(ifb.ovf),     32'(exp_q[0].ovf6));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
    endtask

    task automatic send(input logic c, input logic [3:0] s, input int gap);
        ifa.in_valid = 1'b1;
        ifa.Cout     = c;
        ifa.S        = s;
        tick();
        ifa.in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(ifa.busy),      32'd0);
        chk({tag, "_ir"},    32'(ifa.in_ready),  32'd0);
        chk({tag, "_ov"},    32'(ifa.out_valid), 32'd0);
        chk({tag, "_acc"},   32'(ifa.acc_out),   32'd0);
        chk({tag, "_ovf"},   32'(ifa.ovf),       32'd0);
        chk({tag, "_acc_b"}, 32'(ifb.acc_out),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk         = 0;
        n_err         = 0;
        rst_n         = 1'b1;
        ifa.start     = 1'b0;
        ifa.S         = 4'd0;
        ifa.Cout      = 1'b0;
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;

        // Reset asserted between edges must clear outputs without a clock.
        #3 rst_n = 1'b0;
        #1 chk_all_zero("rst");
        repeat (2) tick();
        #2 rst_n = 1'b1;
        tick();

        // Basic: 3 + 5 + 18 + 15 = 41, result one cycle after the last sample.
        do_start();
        send(1'b0, 4'd3, 0);
        send(1'b0, 4'd5, 0);
        send(1'b1, 4'd2, 0);
        send(1'b0, 4'd15, 0);
        chk("lat_ov",  32'(ifa.out_valid), 32'd1);
        chk("lat_acc", 32'(ifa.acc_out),   32'd41);
        chk("lat_ovf", 32'(ifa.ovf),       32'd0);
        repeat (2) tick();
        chk("idle_keep_acc", 32'(ifa.acc_out), 32'd41);

        // Gaps and backpressure.
        ifa.out_ready = 1'b0;
        do_start();
        send(1'b0, 4'd3, 2);
        send(1'b0, 4'd5, 2);
        send(1'b1, 4'd2, 2);
        send(1'b0, 4'd15, 0);
        repeat (5) tick();
        chk("bp_acc", 32'(ifa.acc_out), 32'd41);
        ifa.out_ready = 1'b1;
        tick();
        chk("bp_idle", 32'(ifa.busy), 32'd0);
        tick();

        // Overflow: 4 x 31 = 124 -> 60 with carry in the 6-bit instance.
        do_start();
        repeat (4) send(1'b1, 4'd15, 0);
        chk("ovf_acc_b", 32'(ifb.acc_out), 32'd60);
        chk("ovf_flag_b", 32'(ifb.ovf),    32'd1);
        chk("ovf_acc_a", 32'(ifa.acc_out), 32'd124);
        chk("ovf_flag_a", 32'(ifa.ovf),    32'd0);
        tick();
        do_start();
        chk("ovf_clear_b", 32'(ifb.ovf), 32'd0);
        repeat (4) send(1'b0, 4'd1, 0);
        repeat (2) tick();

        // Start ignored in ACCUM; start with data in IDLE drops that sample.
        do_start();
        send(1'b0, 4'd7, 0);
        send(1'b0, 4'd1, 0);
        do_start();
        send(1'b0, 4'd2, 0);
        send(1'b0, 4'd4, 0);
        chk("ign_start", 32'(ifa.acc_out), 32'd14);
        tick();
        ifa.start    = 1'b1;
        ifa.in_valid = 1'b1;
        ifa.Cout     = 1'b1;
        ifa.S        = 4'd15;
        tick();
        ifa.start    = 1'b0;
        ifa.in_valid = 1'b0;
        repeat (4) send(1'b0, 4'd2, 0);
        chk("start_data", 32'(ifa.acc_out), 32'd8);
        tick();

        // Reset mid-accumulation, a sample before start, then a clean run.
        do_start();
        send(1'b0, 4'd9, 0);
        send(1'b1, 4'd9, 0);
        #3 rst_n = 1'b0;
        #1 chk_all_zero("mid_rst");
        #2 rst_n = 1'b1;
        tick();
        send(1'b1, 4'd1, 1);
        chk("no_start_acc", 32'(ifa.acc_out), 32'd0);
        do_start();
        repeat (4) send(1'b0, 4'd1, 0);
        chk("post_rst_acc", 32'(ifa.acc_out), 32'd4);
        chk("post_rst_ovf", 32'(ifa.ovf),     32'd0);
        tick();

        // Random runs with random gaps and backpressure.
        for (int t = 0; t < 8; t++) begin
            ifa.out_ready = 1'($urandom_range(0, 1));
            do_start();
            for (int k = 0; k < NS; k++)
                send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom_range(0, 2));
            repeat ($urandom_range(0, 3)) tick();
            ifa.out_ready = 1'b1;
            repeat (2) tick();
        end
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
